// File: rtl/daq_gearbox_fifo.sv
// Single-clock width-converting FIFO: WR_WIDTH-bit words in, RATIO sub-words out per word.
// Optional DAQ_GEARBOX_ERR_EN builds sticky overflow/underflow error registers.
module daq_gearbox_fifo #(
    parameter int WR_WIDTH      = 16,
    parameter int RATIO         = 2,
    parameter int ADDRESS_WIDTH = 6,
    parameter int AF_THRESH     = 56,
    parameter int AE_THRESH     = 4,
    parameter int MSB_FIRST     = 1
) (
    input  logic                        clk,
    input  logic                        clear_n,
    input  logic                        flush,
    input  logic [WR_WIDTH-1:0]         data,
    input  logic                        wrreq,
    output logic                        wrfull,
    output logic [WR_WIDTH/RATIO-1:0]   q,
    input  logic                        rdreq,
    output logic                        rdempty,
    output logic [ADDRESS_WIDTH:0]      usedw,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int SW     = WR_WIDTH / RATIO;
    localparam int LANE_W = $clog2(RATIO);
    localparam int DEPTH  = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0]  FULL_LVL  = (ADDRESS_WIDTH+1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH:0]  AF_LVL    = (ADDRESS_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDRESS_WIDTH:0]  AE_LVL    = (ADDRESS_WIDTH+1)'(AE_THRESH);
    localparam logic [LANE_W-1:0]       LAST_LANE = LANE_W'(RATIO - 1);

    logic [WR_WIDTH-1:0]      mem_q [DEPTH];
    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LANE_W-1:0]        lane_q, lane_d;
    logic [ADDRESS_WIDTH:0]   usedw_q, usedw_d;
    logic [SW-1:0]            q_q, q_d;

    logic                     wr_acc_s, rd_acc_s, release_s;
    logic [WR_WIDTH-1:0]      rd_word_s;
    logic [SW-1:0]            lanes_s [RATIO];

    assign wrfull       = (usedw_q == FULL_LVL);
    assign rdempty      = (usedw_q == '0);
    assign almost_full  = (usedw_q >= AF_LVL);
    assign almost_empty = (usedw_q <= AE_LVL);
    assign usedw        = usedw_q;
    assign q            = q_q;

    // Flush wins over any same-cycle access, so neither side is accepted during it.
    assign wr_acc_s  = wrreq & ~wrfull & ~flush;
    assign rd_acc_s  = rdreq & ~rdempty & ~flush;
    assign release_s = rd_acc_s & (lane_q == LAST_LANE);
    assign rd_word_s = mem_q[rd_ptr_q];

    for (genvar k = 0; k < RATIO; k++) begin : g_lane
        if (MSB_FIRST != 0) begin : g_msb
            assign lanes_s[k] = rd_word_s[(RATIO-1-k)*SW +: SW];
        end else begin : g_lsb
            assign lanes_s[k] = rd_word_s[k*SW +: SW];
        end
    end

    // Next-state for pointers, lane counter, fill level and read data
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        lane_d   = lane_q;
        usedw_d  = usedw_q;
        q_d      = rd_acc_s ? lanes_s[lane_q] : q_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            lane_d   = '0;
            usedw_d  = '0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (release_s) begin
                lane_d   = '0;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else if (rd_acc_s) begin
                lane_d   = lane_q + 1'b1;
            end else begin
                lane_d   = lane_q;
            end
            case ({wr_acc_s, release_s})
                2'b10:   usedw_d = usedw_q + 1'b1;
                2'b01:   usedw_d = usedw_q - 1'b1;
                default: usedw_d = usedw_q;
            endcase
        end
    end

    // Control and read-data registers
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lane_q   <= '0;
            usedw_q  <= '0;
            q_q      <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lane_q   <= lane_d;
            usedw_q  <= usedw_d;
            q_q      <= q_d;
        end
    end

    // Word storage; contents are invalidated by pointer reset, not cleared
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

`ifdef DAQ_GEARBOX_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error capture; only reset clears them
    always_comb begin
        overflow_d  = overflow_q  | (wrreq & wrfull  & ~flush);
        underflow_d = underflow_q | (rdreq & rdempty & ~flush);
    end

    // Error registers
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule
